// File: rtl/preg_freelist_pkg.sv
// Shared core definitions for the physical register file, free list and rename table.
package preg_freelist_pkg;

    localparam int unsigned REG_SIZE       = 64;
    localparam int unsigned REG_SIZE_WIDTH = 6;

    typedef logic [REG_SIZE_WIDTH-1:0] preg_tag_t;

endpackage

// File: rtl/preg_freelist.sv
// Physical-register free list: hands out rename tags, reclaims committed previous mappings,
// and rolls the speculative head back to the committed head on flush.
module preg_freelist
    import preg_freelist_pkg::*;
#(
    parameter int unsigned REG_SIZE       = preg_freelist_pkg::REG_SIZE,
    parameter int unsigned REG_SIZE_WIDTH = preg_freelist_pkg::REG_SIZE_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alloc_req,
    output logic                      alloc_valid,
    output logic [REG_SIZE_WIDTH-1:0] alloc_prd,
    input  logic                      commit_valid,
    input  logic [REG_SIZE_WIDTH-1:0] commit_lprd,
    input  logic                      flush,
    output logic [REG_SIZE_WIDTH:0]   free_count
);

    localparam int unsigned W = REG_SIZE_WIDTH;
    localparam logic [W:0] FULL_CNT = (W+1)'(REG_SIZE - 1);

    logic [W-1:0] ring [REG_SIZE];
    logic [W-1:0] spec_head, spec_head_d;
    logic [W-1:0] commit_head, commit_head_d;
    logic [W-1:0] tail, tail_d;
    logic [W:0]   spec_cnt, spec_cnt_d;
    logic [W:0]   commit_cnt, commit_cnt_d;
    logic         alloc_fire, push;

    assign alloc_valid = (spec_cnt != '0);
    assign alloc_prd   = ring[spec_head];
    assign free_count  = spec_cnt;

    always_comb begin
        alloc_fire    = alloc_req && alloc_valid && !flush;
        push          = commit_valid && (commit_lprd != '0);
        commit_head_d = commit_head + W'(commit_valid);
        tail_d        = tail + W'(push);
        commit_cnt_d  = commit_cnt + (W+1)'(push) - (W+1)'(commit_valid);
        // Rollback uses the post-commit committed view so this cycle's commit is not lost.
        if (flush) begin
            spec_head_d = commit_head_d;
            spec_cnt_d  = commit_cnt_d;
        end else begin
            spec_head_d = spec_head + W'(alloc_fire);
            spec_cnt_d  = spec_cnt + (W+1)'(push) - (W+1)'(alloc_fire);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < REG_SIZE; i++) begin
                ring[i] <= (i < REG_SIZE - 1) ? W'(i + 1) : '0;
            end
            spec_head   <= '0;
            commit_head <= '0;
            tail        <= W'(REG_SIZE - 1);
            spec_cnt    <= FULL_CNT;
            commit_cnt  <= FULL_CNT;
        end else begin
            if (push) begin
                ring[tail] <= commit_lprd;
            end
            spec_head   <= spec_head_d;
            commit_head <= commit_head_d;
            tail        <= tail_d;
            spec_cnt    <= spec_cnt_d;
            commit_cnt  <= commit_cnt_d;
        end
    end

    // A freed tag must not already sit in the allocatable window.
    logic lprd_dup;
    always_comb begin
        lprd_dup = 1'b0;
        for (int unsigned i = 0; i < REG_SIZE; i++) begin
            if (((W+1)'(i) < spec_cnt) && (ring[spec_head + W'(i)] == commit_lprd)) begin
                lprd_dup = 1'b1;
            end
        end
    end

    commit_without_alloc: assert property (@(posedge clk) disable iff (!reset)
        commit_valid |-> (commit_cnt != spec_cnt));
    push_when_full: assert property (@(posedge clk) disable iff (!reset)
        push |-> (spec_cnt != FULL_CNT));
    double_free: assert property (@(posedge clk) disable iff (!reset)
        push |-> !lprd_dup);

endmodule

// File: tb/tb_preg_freelist.sv
// Self-checking bench for preg_freelist: directed scenarios plus randomized legal traffic
// compared against a queue-based model of free, in-flight and architecturally held tags.
module tb_preg_freelist;
    import preg_freelist_pkg::*;

    localparam int W = REG_SIZE_WIDTH;

    logic         clk = 1'b0;
    logic         reset;
    logic         alloc_req;
    logic         alloc_valid;
    logic [W-1:0] alloc_prd;
    logic         commit_valid;
    logic [W-1:0] commit_lprd;
    logic         flush;
    logic [W:0]   free_count;

    int compared   = 0;
    int mismatched = 0;

    // Model: avail = allocatable tags in order, inflight = allocated but uncommitted,
    // arch = committed mappings that may later be freed.
    int avail[$];
    int inflight[$];
    int arch[$];

    always #5 clk = ~clk;

    preg_freelist dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_req    (alloc_req),
        .alloc_valid  (alloc_valid),
        .alloc_prd    (alloc_prd),
        .commit_valid (commit_valid),
        .commit_lprd  (commit_lprd),
        .flush        (flush),
        .free_count   (free_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        avail.delete();
        inflight.delete();
        arch.delete();
        for (int i = 1; i < REG_SIZE; i++) avail.push_back(i);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 32'(alloc_valid), 32'(avail.size() > 0));
        chk({tag, ".count"}, 32'(free_count), 32'(avail.size()));
        if (avail.size() > 0) chk({tag, ".prd"}, 32'(alloc_prd), 32'(avail[0]));
    endtask

    task automatic model_step(input logic a, input logic c, input logic [W-1:0] lprd,
                              input logic f);
        int  got;
        bit  fire;
        fire = a && (avail.size() > 0) && !f;
        got  = 0;
        if (fire) got = avail.pop_front();
        if (c) begin
            arch.push_back(inflight.pop_front());
            if (lprd != '0) avail.push_back(int'(lprd));
        end
        if (fire) inflight.push_back(got);
        if (f) begin
            while (inflight.size() > 0) avail.push_front(inflight.pop_back());
        end
    endtask

    task automatic cycle(input logic a, input logic c, input logic [W-1:0] lprd,
                         input logic f, input string tag);
        alloc_req    = a;
        commit_valid = c;
        commit_lprd  = lprd;
        flush        = f;
        check_outputs(tag);
        @(posedge clk);
        model_step(a, c, lprd, f);
        #1;
        alloc_req    = 1'b0;
        commit_valid = 1'b0;
        commit_lprd  = '0;
        flush        = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    initial begin
        logic         a, c, f;
        logic [W-1:0] lprd;
        int           idx;

        reset        = 1'b0;
        alloc_req    = 1'b0;
        commit_valid = 1'b0;
        commit_lprd  = '0;
        flush        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        chk("reset.valid", 32'(alloc_valid), 32'd1);
        chk("reset.prd", 32'(alloc_prd), 32'd1);
        chk("reset.count", 32'(free_count), 32'd63);

        // Drain: tags 1..63 in order, then empty
        for (int i = 0; i < REG_SIZE - 1; i++) begin
            chk("fill.order", 32'(alloc_prd), 32'(i + 1));
            cycle(1'b1, 1'b0, '0, 1'b0, "fill");
        end
        chk("empty.valid", 32'(alloc_valid), 32'd0);
        chk("empty.count", 32'(free_count), 32'd0);

        // Free into an empty list: no same-cycle bypass
        chk("free5.same_cycle", 32'(alloc_valid), 32'd0);
        cycle(1'b1, 1'b1, W'(5), 1'b0, "free5");
        chk("free5.valid", 32'(alloc_valid), 32'd1);
        chk("free5.prd", 32'(alloc_prd), 32'd5);
        chk("free5.count", 32'(free_count), 32'd1);

        // Alloc 1,2,3; commit one; flush
        apply_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0, "rb.alloc");
        cycle(1'b0, 1'b1, '0, 1'b0, "rb.commit");
        cycle(1'b0, 1'b0, '0, 1'b1, "rb.flush");
        chk("rb.prd", 32'(alloc_prd), 32'd2);
        chk("rb.count", 32'(free_count), 32'd62);

        // Flush together with alloc and commit freeing tag 7
        apply_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, '0, 1'b0, "fx.alloc");
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, '0, 1'b0, "fx.commit");
        cycle(1'b1, 1'b0, '0, 1'b0, "fx.alloc8");
        cycle(1'b1, 1'b0, '0, 1'b0, "fx.alloc9");
        cycle(1'b1, 1'b1, W'(7), 1'b1, "fx.all");
        chk("fx.prd", 32'(alloc_prd), 32'd9);
        chk("fx.count", 32'(free_count), 32'd56);

        // Steady alloc+commit: count constant, pointers wrap
        apply_reset();
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, '0, 1'b0, "wrap.alloc");
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, '0, 1'b0, "wrap.commit");
        cycle(1'b1, 1'b0, '0, 1'b0, "wrap.prime");
        for (int i = 0; i < 200; i++) begin
            lprd = W'(arch.pop_front());
            cycle(1'b1, 1'b1, lprd, 1'b0, "wrap");
            chk("wrap.const_count", 32'(free_count), 32'd53);
        end

        // Asynchronous reset between edges
        alloc_req = 1'b1;
        #3 reset = 1'b0;
        #1;
        chk("areset.valid", 32'(alloc_valid), 32'd1);
        chk("areset.prd", 32'(alloc_prd), 32'd1);
        chk("areset.count", 32'(free_count), 32'd63);
        alloc_req = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_outputs("areset.after");

        // Randomized legal traffic
        for (int n = 0; n < 3000; n++) begin
            a    = ($urandom_range(0, 3) != 0);
            c    = (inflight.size() > 0) && ($urandom_range(0, 2) != 0);
            f    = ($urandom_range(0, 39) == 0);
            lprd = '0;
            if (c && arch.size() > 0 && $urandom_range(0, 3) != 0) begin
                idx  = int'($urandom_range(0, arch.size() - 1));
                lprd = W'(arch[idx]);
                arch.delete(idx);
            end
            cycle(a, c, lprd, f, "rand");
        end
        check_outputs("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
